// File: rtl/wave_cfg_pkg.sv
// Shared definitions for the SPI wave-generator configuration front-end:
// register addresses, waveform encodings and FSM states.
package wave_cfg_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_FREQ_LO = 3'd1;
    localparam logic [2:0] ADDR_FREQ_HI = 3'd2;
    localparam logic [2:0] ADDR_AMP     = 3'd3;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_TRI    = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_SQUARE = 2'd3
    } wave_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for one SPI pin, with rising/falling edge
// detection taken from the last two synchronised samples.
module spi_input_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_wave_config.sv
// SPI slave (mode 0, oversampled on clk) decoding 16-bit frames into wave
// generator controls. Define SPI_READBACK_EN to enable register readback on miso.
module spi_wave_config
    import wave_cfg_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] FREQ_RESET  = 16'h0000,
    parameter logic [7:0]  AMP_RESET   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        gen_enable,
    output logic [1:0]  wave_sel,
    output logic [15:0] freq_word,
    output logic [7:0]  amplitude,
    output logic        cfg_update
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    // cs_n resets high so that leaving reset never looks like a frame start
    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(spi_sclk), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(spi_cs_n), .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall));
    spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(spi_mosi), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [15:0] shift_q;
    logic [15:0] shift_d;
    logic [7:0]  freq_lo_q;

    assign shift_d = {shift_q[14:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            shift_q    <= 16'h0000;
            freq_lo_q  <= 8'h00;
            gen_enable <= 1'b0;
            wave_sel   <= WAVE_SINE;
            freq_word  <= FREQ_RESET;
            amplitude  <= AMP_RESET;
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= 5'd0;
                        shift_q <= 16'h0000;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        state_q <= IDLE;
                    end else if (sclk_rise) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 5'd1;
                        if (cnt_q == 5'(FRAME_BITS - 1)) state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= WAIT;
                    if (!shift_q[15]) begin
                        case (shift_q[14:12])
                            ADDR_CTRL: begin
                                gen_enable <= shift_q[0];
                                wave_sel   <= shift_q[2:1];
                                cfg_update <= 1'b1;
                            end
                            ADDR_FREQ_LO: freq_lo_q <= shift_q[7:0];
                            ADDR_FREQ_HI: begin
                                freq_word  <= {shift_q[7:0], freq_lo_q};
                                cfg_update <= 1'b1;
                            end
                            ADDR_AMP: begin
                                amplitude  <= shift_q[7:0];
                                cfg_update <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT: begin
                    if (cs_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic       rd_active_q;
    logic [7:0] miso_sh_q;
    logic [7:0] rd_val;

    always_comb begin
        rd_val = 8'h00;
        case (shift_d[6:4])
            ADDR_CTRL:    rd_val = {5'b0, wave_sel, gen_enable};
            ADDR_FREQ_LO: rd_val = freq_lo_q;
            ADDR_FREQ_HI: rd_val = freq_word[15:8];
            ADDR_AMP:     rd_val = amplitude;
            default:      rd_val = 8'h00;
        endcase
    end

    // Loaded on the 8th rising edge; the falling edge right after it keeps the
    // MSB on the pin so the master samples bit 7 on the 9th rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_active_q <= 1'b0;
            miso_sh_q   <= 8'h00;
        end else if (state_q != SHIFT || cs_s) begin
            rd_active_q <= 1'b0;
            miso_sh_q   <= 8'h00;
        end else if (sclk_rise && cnt_q == 5'd7) begin
            rd_active_q <= shift_d[7];
            miso_sh_q   <= shift_d[7] ? rd_val : 8'h00;
        end else if (sclk_fall && rd_active_q && cnt_q >= 5'd9) begin
            miso_sh_q <= {miso_sh_q[6:0], 1'b0};
        end
    end

    assign spi_miso = rd_active_q & miso_sh_q[7];

    logic unused_sig;
    assign unused_sig = ^{sclk_s, cs_rise, mosi_rise, mosi_fall, shift_q[11:8]};
`else
    assign spi_miso = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{sclk_s, sclk_fall, cs_rise, mosi_rise, mosi_fall, shift_q[11:8]};
`endif

endmodule

// File: tb/tb_spi_wave_config.sv
// Directed testbench for spi_wave_config; honours SPI_READBACK_EN.
module tb_spi_wave_config;

    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        gen_enable;
    logic [1:0]  wave_sel;
    logic [15:0] freq_word;
    logic [7:0]  amplitude;
    logic        cfg_update;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    int edge16_cyc = 0;
    logic miso_seen = 1'b0;
    logic [7:0] rd;

    spi_wave_config #(.SYNC_STAGES(SYNC), .FREQ_RESET(16'h0000), .AMP_RESET(8'hFF)) dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .gen_enable(gen_enable),
        .wave_sel(wave_sel), .freq_word(freq_word), .amplitude(amplitude),
        .cfg_update(cfg_update));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cfg_update === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
        end
        if (spi_miso === 1'b1) miso_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_frame(input logic [31:0] data, input int nbits, input int abort_at,
                             output logic [7:0] rdata);
        rdata = 8'h00;
        spi_cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) break;
            spi_mosi = data[nbits-1-i];
            tick(HALF);
            if (i >= 8 && i < 16) rdata[15-i] = spi_miso;
            spi_sclk = 1'b1;
            if (i == 15) edge16_cyc = cyc;
            tick(HALF);
            spi_sclk = 1'b0;
        end
        tick(4);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick(8);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(2);
        miso_seen = 1'b0;
        pulse_cnt = 0;
        n_checks++; if (gen_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b exp 0", gen_enable); end
        n_checks++; if (wave_sel !== 2'd0) begin n_fail++; $display("FAIL reset_wave: got %0d exp 0", wave_sel); end
        n_checks++; if (freq_word !== 16'h0000) begin n_fail++; $display("FAIL reset_freq: got %h exp 0000", freq_word); end
        n_checks++; if (amplitude !== 8'hFF) begin n_fail++; $display("FAIL reset_amp: got %h exp ff", amplitude); end
        n_checks++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b exp 0", cfg_update); end
        n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b exp 0", spi_miso); end
    endtask

    task automatic test_freq;
        pulse_cnt = 0;
        spi_frame(32'h1034, 16, 99, rd);
        n_checks++; if (freq_word !== 16'h0000) begin n_fail++; $display("FAIL freq_lo_only: got %h exp 0000", freq_word); end
        n_checks++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL freq_lo_pulse: got %0d exp 0", pulse_cnt); end
        spi_frame(32'h2012, 16, 99, rd);
        n_checks++; if (freq_word !== 16'h1234) begin n_fail++; $display("FAIL freq_commit: got %h exp 1234", freq_word); end
        n_checks++; if (pulse_cnt !== 1) begin n_fail++; $display("FAIL freq_pulse: got %0d exp 1", pulse_cnt); end
    endtask

    task automatic test_ctrl;
        pulse_cnt = 0;
        spi_frame(32'h0005, 16, 99, rd);
        n_checks++; if (gen_enable !== 1'b1) begin n_fail++; $display("FAIL ctrl_enable: got %b exp 1", gen_enable); end
        n_checks++; if (wave_sel !== 2'd2) begin n_fail++; $display("FAIL ctrl_wave: got %0d exp 2", wave_sel); end
        n_checks++; if (pulse_cnt !== 1) begin n_fail++; $display("FAIL ctrl_pulse: got %0d exp 1", pulse_cnt); end
        n_checks++;
        if (pulse_cnt < 1 || pulse_cyc - edge16_cyc > SYNC + 2 || pulse_cyc - edge16_cyc < 1) begin
            n_fail++; $display("FAIL ctrl_latency: got %0d cycles exp 1..%0d", pulse_cyc - edge16_cyc, SYNC + 2);
        end
    endtask

    task automatic test_abort;
        pulse_cnt = 0;
        spi_frame(32'h3040, 16, 10, rd);
        n_checks++; if (amplitude !== 8'hFF) begin n_fail++; $display("FAIL abort_amp: got %h exp ff", amplitude); end
        n_checks++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL abort_pulse: got %0d exp 0", pulse_cnt); end
        spi_frame(32'h3040, 16, 99, rd);
        n_checks++; if (amplitude !== 8'h40) begin n_fail++; $display("FAIL after_abort_amp: got %h exp 40", amplitude); end
        n_checks++; if (pulse_cnt !== 1) begin n_fail++; $display("FAIL after_abort_pulse: got %0d exp 1", pulse_cnt); end
    endtask

    task automatic test_unmapped_long;
        pulse_cnt = 0;
        spi_frame(32'h5077, 16, 99, rd);
        n_checks++;
        if ({gen_enable, wave_sel, freq_word, amplitude} !== {1'b1, 2'd2, 16'h1234, 8'h40}) begin
            n_fail++; $display("FAIL unmapped_regs: got %b %0d %h %h exp 1 2 1234 40", gen_enable, wave_sel, freq_word, amplitude);
        end
        n_checks++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL unmapped_pulse: got %0d exp 0", pulse_cnt); end
        spi_frame({12'h000, 16'h3022, 4'hF}, 20, 99, rd);
        n_checks++; if (amplitude !== 8'h22) begin n_fail++; $display("FAIL long_amp: got %h exp 22", amplitude); end
        n_checks++; if (pulse_cnt !== 1) begin n_fail++; $display("FAIL long_pulse: got %0d exp 1", pulse_cnt); end
        n_checks++; if (freq_word !== 16'h1234) begin n_fail++; $display("FAIL long_freq: got %h exp 1234", freq_word); end
    endtask

    task automatic test_readback;
        spi_frame(32'h30A5, 16, 99, rd);
        n_checks++; if (amplitude !== 8'hA5) begin n_fail++; $display("FAIL rb_setup_amp: got %h exp a5", amplitude); end
        pulse_cnt = 0;
        miso_seen = 1'b0;
        spi_frame(32'hB000, 16, 99, rd);
`ifdef SPI_READBACK_EN
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL rb_data: got %b exp 10100101", rd); end
`else
        n_checks++; if (rd !== 8'h00 || miso_seen !== 1'b0) begin n_fail++; $display("FAIL rb_miso_idle: got %h seen %b exp 00 seen 0", rd, miso_seen); end
`endif
        n_checks++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL rb_pulse: got %0d exp 0", pulse_cnt); end
        n_checks++; if (amplitude !== 8'hA5) begin n_fail++; $display("FAIL rb_amp: got %h exp a5", amplitude); end
        n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL rb_miso_after: got %b exp 0", spi_miso); end
    endtask

    task automatic test_reset_midframe;
        spi_cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 6; i++) begin
            spi_mosi = 1'b1; tick(HALF); spi_sclk = 1'b1; tick(HALF); spi_sclk = 1'b0;
        end
        rst = 1'b1;
        tick(1);
        n_checks++;
        if ({gen_enable, wave_sel, freq_word, amplitude, cfg_update} !== {1'b0, 2'd0, 16'h0000, 8'hFF, 1'b0}) begin
            n_fail++; $display("FAIL midframe_reset: got %b %0d %h %h %b exp 0 0 0000 ff 0", gen_enable, wave_sel, freq_word, amplitude, cfg_update);
        end
        rst = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick(8);
        pulse_cnt = 0;
        spi_frame(32'h3011, 16, 99, rd);
        n_checks++; if (amplitude !== 8'h11 || pulse_cnt !== 1) begin n_fail++; $display("FAIL post_reset_frame: got %h/%0d exp 11/1", amplitude, pulse_cnt); end
    endtask

    initial begin
        test_reset();
        test_freq();
        test_ctrl();
        test_abort();
        test_unmapped_long();
        test_readback();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
